// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, common keyboard commands and frame sizing.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Data bits + parity + stop, shifted out after the start bit.
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned TIMER_W    = 20;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status handshake between a PS/2 command client and ps2_host_tx.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       ack_ok;
  logic       err_nack;
  logic       err_timeout;

  modport master (
    output tx_data, tx_start,
    input  busy, rx_inhibit, done, ack_ok, err_nack, err_timeout
  );

  modport slave (
    input  tx_data, tx_start,
    output busy, rx_inhibit, done, ack_ok, err_nack, err_timeout
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a clock falling-edge detector.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2c_sync,
  output logic ps2d_sync,
  output logic ps2c_fall_c
);

  // c_pipe: [0] metastable stage, [1] current, [2] previous
  logic [2:0] c_pipe_q, c_pipe_d;
  logic [1:0] d_pipe_q, d_pipe_d;

  always_comb begin
    c_pipe_d = {c_pipe_q[1:0], ps2c_in};
    d_pipe_d = {d_pipe_q[0], ps2d_in};
  end

  // Reset to the idle-high line level so no edge appears out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_pipe_q <= '1;
      d_pipe_q <= '1;
    end else begin
      c_pipe_q <= c_pipe_d;
      d_pipe_q <= d_pipe_d;
    end
  end

  assign ps2c_sync   = c_pipe_q[1];
  assign ps2d_sync   = d_pipe_q[1];
  assign ps2c_fall_c = c_pipe_q[2] & ~c_pipe_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain pads through output enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned IDLE_CYCLES    = 2500
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  host,
  input  logic          ps2c_in,
  input  logic          ps2d_in,
  output logic          ps2c_oe,
  output logic          ps2d_oe
);

  localparam logic [TIMER_W-1:0] INH_START = TIMER_W'(INHIBIT_CYCLES - 2);
  localparam logic [TIMER_W-1:0] INH_LAST  = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] IDLE_LAST = TIMER_W'(IDLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TIMER_W-1:0]      timer_q, timer_d, timer_inc;
  logic                    nack_q, nack_d;
  logic                    c_oe_q, c_oe_d;
  logic                    d_oe_q, d_oe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ack_ok_q, ack_ok_d;
  logic                    err_nack_q, err_nack_d;
  logic                    err_timeout_q, err_timeout_d;

  logic c_sync, d_sync, c_fall_c;
  logic accept_c;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_sync   (c_sync),
    .ps2d_sync   (d_sync),
    .ps2c_fall_c (c_fall_c)
  );

  // Single timer reused as inhibit length, ACK timeout and idle-high run length.
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
  assign accept_c  = host.tx_start && !busy_q && !done_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    timer_d       = timer_q;
    nack_d        = nack_q;
    c_oe_d        = c_oe_q;
    d_oe_d        = d_oe_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ack_ok_d      = 1'b0;
    err_nack_d    = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          shift_d   = {1'b1, odd_parity(host.tx_data), host.tx_data};
          bit_cnt_d = '0;
          timer_d   = '0;
          nack_d    = 1'b0;
          busy_d    = 1'b1;
          c_oe_d    = 1'b1;
          d_oe_d    = 1'b0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        timer_d = timer_inc;
        if (timer_q == INH_START) d_oe_d = 1'b1;
        if (timer_q == INH_LAST) begin
          c_oe_d  = 1'b0;
          state_d = REQ;
        end
      end

      // Clock just released: this cycle is the first of the timeout window.
      REQ: begin
        timer_d = TIMER_W'(1);
        state_d = BITS;
      end

      BITS: begin
        timer_d = timer_inc;
        if (c_fall_c) begin
          d_oe_d    = ~shift_q[0];
          shift_d   = {1'b0, shift_q[FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = ACK;
        end
      end

      ACK: begin
        timer_d = timer_inc;
        if (c_fall_c) begin
          nack_d  = d_sync;
          timer_d = '0;
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (c_sync && d_sync) begin
          timer_d = timer_inc;
          if (timer_q == IDLE_LAST) begin
            done_d     = 1'b1;
            ack_ok_d   = ~nack_q;
            err_nack_d = nack_q;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end else begin
          timer_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // A clock edge in the same cycle takes precedence over the timeout.
    if ((state_q == BITS || state_q == ACK) && !c_fall_c && timer_q >= TOUT_LAST) begin
      c_oe_d        = 1'b0;
      d_oe_d        = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b1;
      err_timeout_d = 1'b1;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      nack_q        <= 1'b0;
      c_oe_q        <= 1'b0;
      d_oe_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ack_ok_q      <= 1'b0;
      err_nack_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      timer_q       <= timer_d;
      nack_q        <= nack_d;
      c_oe_q        <= c_oe_d;
      d_oe_q        <= d_oe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ack_ok_q      <= ack_ok_d;
      err_nack_q    <= err_nack_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign ps2c_oe          = c_oe_q;
  assign ps2d_oe          = d_oe_q;
  assign host.busy        = busy_q;
  assign host.rx_inhibit  = busy_q;
  assign host.done        = done_q;
  assign host.ack_ok      = ack_ok_q;
  assign host.err_nack    = err_nack_q;
  assign host.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model on the pads.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int TOUT = 3000;
  localparam int IDLE = 100;
  localparam int HP   = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  logic dev_c = 1'b1;
  logic dev_d = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  ps2_host_tx_if hif ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TOUT),
    .IDLE_CYCLES    (IDLE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .host    (hif),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe)
  );

  always #5 clk = ~clk;

  assign ps2c_in = ~ps2c_oe & dev_c;
  assign ps2d_in = ~ps2d_oe & dev_d;

  always @(negedge clk) if (hif.done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    hif.tx_data  = b;
    hif.tx_start = 1'b1;
    @(negedge clk);
    hif.tx_start = 1'b0;
  endtask

  // Returns on the first negedge with the clock line released.
  task automatic inhibit_phase(output int c_len, output int d_len);
    c_len = 0;
    d_len = 0;
    while (ps2c_oe === 1'b1 && c_len < 10 * INH) begin
      c_len++;
      if (ps2d_oe === 1'b1) d_len++;
      @(negedge clk);
    end
  endtask

  // Device clocks out 10 bits, sampling data on each rising edge, then gives the ACK pulse.
  task automatic device_frame(input bit ack, input int hold, output logic [9:0] bits,
                              output logic busy_ok);
    busy_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (HP) begin @(negedge clk); if (hif.busy !== 1'b1) busy_ok = 1'b0; end
      dev_c = 1'b0;
      repeat (HP) begin @(negedge clk); if (hif.busy !== 1'b1) busy_ok = 1'b0; end
      dev_c = 1'b1;
      bits[i] = ps2d_in;
    end
    repeat (HP) @(negedge clk);
    dev_d = ack ? 1'b0 : 1'b1;
    repeat (4) @(negedge clk);
    dev_c = 1'b0;
    repeat (HP) @(negedge clk);
    dev_c = 1'b1;
    dev_d = 1'b1;
    if (hold > 0) begin
      repeat (HP) @(negedge clk);
      dev_c = 1'b0;
      repeat (hold) @(negedge clk);
      dev_c = 1'b1;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (hif.done !== 1'b1 && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int         c_len, d_len, lat, n0;
    logic [9:0] bits;
    logic       bok;

    hif.tx_data  = 8'h00;
    hif.tx_start = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ps2c_oe", ps2c_oe, 0);
    chk("rst_ps2d_oe", ps2d_oe, 0);
    chk("rst_busy", hif.busy, 0);
    chk("rst_rx_inhibit", hif.rx_inhibit, 0);
    chk("rst_done", hif.done, 0);
    chk("rst_ack_ok", hif.ack_ok, 0);
    chk("rst_err_nack", hif.err_nack, 0);
    chk("rst_err_timeout", hif.err_timeout, 0);

    // tx_start while reset is held is not accepted
    hif.tx_data  = CMD_SET_LEDS;
    hif.tx_start = 1'b1;
    @(negedge clk);
    hif.tx_start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", hif.busy, 0);
    chk("rst_start_ps2c_oe", ps2c_oe, 0);

    // 0xED with ACK
    start_tx(CMD_SET_LEDS);
    chk("ed_rx_inhibit", hif.rx_inhibit, 1);
    inhibit_phase(c_len, d_len);
    chk("ed_inhibit_len", c_len, INH);
    chk("ed_start_overlap", d_len, 1);
    chk("ed_start_bit", ps2d_oe, 1);
    device_frame(1'b1, 0, bits, bok);
    chk("ed_data", bits[7:0], 8'hED);
    chk("ed_parity", bits[8], 1);
    chk("ed_stop", bits[9], 1);
    chk("ed_busy_frame", bok, 1);
    wait_done(lat);
    chk("ed_idle_latency", lat, IDLE + 2);
    chk("ed_ack_ok", hif.ack_ok, 1);
    chk("ed_err_nack", hif.err_nack, 0);
    chk("ed_err_timeout", hif.err_timeout, 0);
    @(negedge clk);
    chk("ed_done_pulse_len", hif.done, 0);
    chk("ed_ack_ok_after", hif.ack_ok, 0);
    chk("ed_busy_after", hif.busy, 0);

    // 0xF4 with NACK; a tx_start on the done cycle is ignored
    start_tx(CMD_ENABLE);
    inhibit_phase(c_len, d_len);
    device_frame(1'b0, 0, bits, bok);
    chk("f4_data", bits[7:0], 8'hF4);
    chk("f4_parity", bits[8], 0);
    chk("f4_stop", bits[9], 1);
    wait_done(lat);
    chk("f4_done", hif.done, 1);
    chk("f4_err_nack", hif.err_nack, 1);
    chk("f4_ack_ok", hif.ack_ok, 0);
    chk("f4_err_timeout", hif.err_timeout, 0);
    hif.tx_data  = CMD_RESET;
    hif.tx_start = 1'b1;
    @(negedge clk);
    hif.tx_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("done_cycle_start_oe", ps2c_oe, 0);
    chk("done_cycle_start_busy", hif.busy, 0);

    // 0xFF with a silent device: timeout
    start_tx(CMD_RESET);
    inhibit_phase(c_len, d_len);
    chk("ff_inhibit_len", c_len, INH);
    wait_done(lat);
    chk("ff_timeout_latency", lat, TOUT);
    chk("ff_err_timeout", hif.err_timeout, 1);
    chk("ff_ack_ok", hif.ack_ok, 0);
    chk("ff_err_nack", hif.err_nack, 0);
    chk("ff_ps2c_oe", ps2c_oe, 0);
    chk("ff_ps2d_oe", ps2d_oe, 0);
    chk("ff_busy", hif.busy, 0);

    // Reset at edge 5 of a 0xED frame
    start_tx(CMD_SET_LEDS);
    inhibit_phase(c_len, d_len);
    for (int i = 0; i < 5; i++) begin
      repeat (HP) @(negedge clk);
      dev_c = 1'b0;
      if (i < 4) begin
        repeat (HP) @(negedge clk);
        dev_c = 1'b1;
      end
    end
    repeat (4) @(negedge clk);
    chk("mid_ps2d_oe_bit4", ps2d_oe, 1);
    n0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ps2c_oe", ps2c_oe, 0);
    chk("mid_rst_ps2d_oe", ps2d_oe, 0);
    chk("mid_rst_busy", hif.busy, 0);
    chk("mid_rst_done", hif.done, 0);
    dev_c = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - n0, 0);
    start_tx(CMD_ENABLE);
    inhibit_phase(c_len, d_len);
    device_frame(1'b1, 0, bits, bok);
    chk("post_rst_data", bits[7:0], 8'hF4);
    wait_done(lat);
    chk("post_rst_ack_ok", hif.ack_ok, 1);

    // Stray tx_start of 0x00 during an active 0xED frame
    start_tx(CMD_SET_LEDS);
    inhibit_phase(c_len, d_len);
    n0 = done_cnt;
    fork
      device_frame(1'b1, 0, bits, bok);
      begin
        repeat (150) @(negedge clk);
        hif.tx_data  = 8'h00;
        hif.tx_start = 1'b1;
        @(negedge clk);
        hif.tx_start = 1'b0;
      end
    join
    chk("stray_data", bits[7:0], 8'hED);
    chk("stray_parity", bits[8], 1);
    wait_done(lat);
    chk("stray_ack_ok", hif.ack_ok, 1);
    repeat (200) @(negedge clk);
    chk("stray_done_count", done_cnt - n0, 1);
    chk("stray_ps2c_oe", ps2c_oe, 0);

    // Device holds clock low after the ACK: done waits for a full idle run
    start_tx(CMD_SET_LEDS);
    inhibit_phase(c_len, d_len);
    device_frame(1'b1, 2 * HP, bits, bok);
    chk("hold_busy", hif.busy, 1);
    wait_done(lat);
    chk("hold_idle_latency", lat, IDLE + 2);
    chk("hold_ack_ok", hif.ack_ok, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
